// File: rtl/updown_mod_counter.sv
//------------------------------------------------------------------------------
// Module   : updown_mod_counter
// Purpose  : Up/down modulo-MOD_VAL counter. It supports a synchronous load with
//            clamp, a count enable, a direction input and a runtime wrap or
//            saturate mode. It also provides terminal-count, wrap-pulse and
//            saturate-pulse status.
// Options  : UDCNT_STICKY_OVF_EN adds ovf_clr / ovf_sticky, a sticky flag
//            raised by any wrap or saturate event.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MOD_VAL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDCNT_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Highest legal count. The value is truncated to WIDTH bits, so the
    // MOD_VAL == 2**WIDTH case gives all-ones.
    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    // Reject a modulus that cannot be represented or counted.
    generate
        if ((MOD_VAL < 2) || (longint'(MOD_VAL) > (longint'(1) << WIDTH))) begin : g_param_check
            $fatal(1, "updown_mod_counter: MOD_VAL must satisfy 2 <= MOD_VAL <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt_q == C_MAX);
    assign at_zero = (cnt_q == C_ZERO);

    // Next count and event pulses. Load beats enable, and enable beats hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (load) begin
            cnt_d = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    cnt_d = cnt_q + C_ONE;
                end else if (!mode) begin
                    cnt_d  = C_ZERO;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    cnt_d = cnt_q - C_ONE;
                end else if (!mode) begin
                    cnt_d  = C_MAX;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    // Count and status registers. Reset clears them at once and drops any pending pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= C_ZERO;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

`ifdef UDCNT_STICKY_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow. A set event wins over a clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (wrap_d || sat_d) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`endif

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;
    // Terminal count follows direction immediately, without waiting for a clock edge.
    assign tc   = (up & at_max) | (~up & at_zero);

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_updown_mod_counter
// Purpose  : Scoreboard bench for updown_mod_counter. Two instances run side by
//            side: a MOD_VAL=10 counter in a 4-bit register, and a full-range
//            MOD_VAL=8 counter in a 3-bit register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, mode = 1'b0, load = 1'b0;
    logic [3:0] load_val1 = '0;
    logic [2:0] load_val2 = '0;
    logic [3:0] q1;
    logic [2:0] q2;
    logic       tc1, wrap1, sat1, tc2, wrap2, sat2;
`ifdef UDCNT_STICKY_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf1, ovf2;
`endif

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MOD_VAL(10)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val1),
`ifdef UDCNT_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf1),
`endif
        .q(q1), .tc(tc1), .wrap(wrap1), .sat(sat1)
    );

    updown_mod_counter #(.WIDTH(3), .MOD_VAL(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode), .load(load),
        .load_val(load_val2),
`ifdef UDCNT_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf2),
`endif
        .q(q2), .tc(tc2), .wrap(wrap2), .sat(sat2)
    );

    typedef struct {
        int q1; bit w1; bit s1; bit t1; bit o1;
        int q2; bit w2; bit s2; bit t2; bit o2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   drv_done    = 1'b0;

    // Reference model state
    int m1_q = 0, m2_q = 0;
    bit m1_o = 1'b0, m2_o = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural step: move one position on a ring of size mod. Falling off
    // either end is a boundary event.
    function automatic void model(input int mod, input int cur, input bit e, input bit u,
                                  input bit m, input bit l, input int lv,
                                  output int nxt, output bit w, output bit s);
        int t;
        nxt = cur; w = 1'b0; s = 1'b0;
        if (l) begin
            nxt = (lv > mod - 1) ? mod - 1 : lv;
        end else if (e) begin
            t = u ? cur + 1 : cur - 1;
            if (t >= 0 && t < mod) nxt = t;
            else if (m) s = 1'b1;
            else begin
                nxt = (t + mod) % mod;
                w = 1'b1;
            end
        end
    endfunction

    function automatic bit tc_of(input int mod, input int qv, input bit u);
        return (u && qv == mod - 1) || (!u && qv == 0);
    endfunction

    // Apply one cycle of stimulus and queue the response expected after the edge.
    task automatic drive(input bit e, input bit u, input bit m, input bit l, input int lv,
                         input bit clr);
        exp_t x;
        int   lv1, lv2;
        @(negedge clk);
        lv1 = lv & 15;
        lv2 = lv & 7;
        en = e; up = u; mode = m; load = l;
        load_val1 = lv1[3:0];
        load_val2 = lv2[2:0];
`ifdef UDCNT_STICKY_OVF_EN
        ovf_clr = clr;
`endif
        model(10, m1_q, e, u, m, l, lv1, x.q1, x.w1, x.s1);
        model(8,  m2_q, e, u, m, l, lv2, x.q2, x.w2, x.s2);
        if (x.w1 || x.s1) m1_o = 1'b1; else if (clr) m1_o = 1'b0;
        if (x.w2 || x.s2) m2_o = 1'b1; else if (clr) m2_o = 1'b0;
        m1_q = x.q1; m2_q = x.q2;
        x.o1 = m1_o; x.o2 = m2_o;
        x.t1 = tc_of(10, x.q1, u);
        x.t2 = tc_of(8,  x.q2, u);
        exp_q.push_back(x);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " q1"}, int'(q1), 0);
        chk({tag, " q2"}, int'(q2), 0);
        chk({tag, " wrap"}, int'(wrap1 | wrap2), 0);
        chk({tag, " sat"}, int'(sat1 | sat2), 0);
`ifdef UDCNT_STICKY_OVF_EN
        chk({tag, " ovf"}, int'(ovf1 | ovf2), 0);
`endif
    endtask

    // Monitor: compare the outputs after each rising edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q1", int'(q1), e.q1);
                chk("wrap1", int'(wrap1), int'(e.w1));
                chk("sat1", int'(sat1), int'(e.s1));
                chk("tc1", int'(tc1), int'(e.t1));
                chk("q2", int'(q2), e.q2);
                chk("wrap2", int'(wrap2), int'(e.w2));
                chk("sat2", int'(sat2), int'(e.s2));
                chk("tc2", int'(tc2), int'(e.t2));
`ifdef UDCNT_STICKY_OVF_EN
                chk("ovf1", int'(ovf1), int'(e.o1));
                chk("ovf2", int'(ovf2), int'(e.o2));
`endif
            end
        end
    end

    // Stimulus
    initial begin
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Count up with wrap, then count down through zero
        for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0);

        // Saturate at top, then step down
        drive(0, 1, 1, 1, 9, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        // Saturate at bottom
        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 0, 1, 0, 0, 0);

        // Load clamp, and load beats enable
        drive(1, 1, 0, 1, 13, 0);
        drive(1, 1, 0, 1, 4, 0);
        drive(1, 1, 0, 0, 0, 0);

        // Sticky flag: set by a wrap, held while idle, cleared, then a set on the same edge as a clear
        drive(0, 1, 0, 1, 9, 0);
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 9, 0);
        drive(1, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);

        // Reset asserted in the middle of a cycle while the count is 6
        drive(0, 1, 0, 1, 6, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async reset");
        m1_q = 0; m2_q = 0; m1_o = 1'b0; m2_o = 1'b0;
        en = 1'b0; load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(1, 1, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        drv_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        if (!drv_done) begin
            miscompares++;
            $display("FAIL watchdog: got timeout, expected completion");
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $fatal(1, "bench timeout");
        end
    end

endmodule

`default_nettype wire

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised up/down modulo-N counter. Adds synchronous load, count enable, direction control and a runtime wrap/saturate mode. Provides terminal-count and wrap-event status outputs. Used as the general-purpose counter for timers, address generators and divider chains.

Parameters:
WIDTH, 4, counter register width in bits.
MOD_VAL, 16, count modulus; legal range is 0..MOD_VAL-1; constraint 2 <= MOD_VAL <= 2**WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous active-low reset; rst=0 forces reset immediately.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value loaded when load=1.
q  output  WIDTH  registered count value.
tc  output  1  terminal count, combinational from q and up.
wrap  output  1  registered one-cycle pulse flagging a wrap event.
sat  output  1  registered one-cycle pulse flagging a blocked step at a boundary in saturate mode.

Behaviour:
- Reset (rst=0, asynchronous): q=0, wrap=0, sat=0. On rst release, the first rising clk edge counts normally.
- Per-edge priority: load > en > hold.
- load=1:
  - q <= load_val if load_val <= MOD_VAL-1, otherwise q <= MOD_VAL-1 (clamp).
  - wrap <= 0, sat <= 0. en is ignored.
- en=1, load=0, up=1:
  - If q < MOD_VAL-1: q <= q+1.
  - If q == MOD_VAL-1 and mode=0: q <= 0, wrap <= 1.
  - If q == MOD_VAL-1 and mode=1: q holds, sat <= 1.
- en=1, load=0, up=0:
  - If q > 0: q <= q-1.
  - If q == 0 and mode=0: q <= MOD_VAL-1, wrap <= 1.
  - If q == 0 and mode=1: q holds, sat <= 0... corrected: q holds, sat <= 1.
- en=0, load=0: q holds, wrap <= 0, sat <= 0.
- wrap and sat are high for exactly one cycle per event. Both stay high on back-to-back events, e.g. continuous saturation keeps sat=1 each cycle.
- tc = (up & q==MOD_VAL-1) | (~up & q==0). It is independent of en and mode, and changes immediately when up toggles.
- Arithmetic: all compares are done at WIDTH bits. When MOD_VAL == 2**WIDTH, wrap occurs at the all-ones/zero boundary with no overflow artefacts.
- Direction and mode may change on any cycle; the new values take effect on the next edge.
- Reset asserted mid-count: q clears asynchronously and pending pulses are dropped.
- Illegal parameters (MOD_VAL < 2 or MOD_VAL > 2**WIDTH): an elaboration-time check halts simulation with an error.

Optional Feature:
Macro: UDCNT_STICKY_OVF_EN.
- Defined: adds input ovf_clr (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky is set on any edge where wrap or sat would be set, and stays high until an edge with ovf_clr=1.
  - If a set event and ovf_clr=1 occur on the same edge, set wins.
  - ovf_sticky resets to 0.
- Undefined: neither port exists; there is no sticky logic.

Test Plan:
- WIDTH=4, MOD_VAL=10, mode=0, up=1, en=1 for 12 cycles from reset -> q runs 1..9,0,1,2; wrap=1 only in the cycle after q 9->0; tc=1 while q=9.
- Same config, up=0, from q=0 -> q=9 with wrap pulse, then 8,7; tc=1 when q=0 with up=0.
- mode=1, load load_val=9, up=1, en=1 for 3 cycles -> q stays 9; sat=1 for all 3 cycles; wrap=0. Then up=0 -> q=8, sat=0.
- load=1 with load_val=13 while en=1 -> q=9 (clamped), no increment that cycle; load_val=4 -> q=4.
- Drive rst=0 mid-cycle while q=6 -> q=0 before the next clk edge; wrap and sat = 0; counting resumes 1,2 after release.
- With UDCNT_STICKY_OVF_EN defined: force a wrap -> ovf_sticky=1 and held for 5 idle cycles. ovf_clr=1 -> 0. ovf_clr=1 coincident with a wrap -> ovf_sticky stays 1.
